serial_mag_cmp_ctrl: RTL and testbench
======================================

# serial_mag_cmp_ctrl

Sequential controller that performs an N-bit unsigned magnitude comparison with a single-bit comparator cell (gt = a&~b, eq = ~(a^b), lt = ~a&b). It scans operand bits MSB-first, one bit per clock, and stops at the first mismatching bit. It sits between a requesting datapath (start/done handshake) and the 1-bit comparator, and reports a registered one-hot result plus the number of bits examined.

## Interface
- WIDTH, 8, operand width in bits (WIDTH ≥ 2)
- CW, $clog2(WIDTH)+1, width of bits_checked (derived, not overridden)

- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a comparison; accepted only in IDLE
- a  input  WIDTH  operand A, sampled on the accept edge only
- b  input  WIDTH  operand B, sampled on the accept edge only
- busy  output  1  high while in SCAN
- done  output  1  one-cycle pulse; result valid
- gt  output  1  A > B
- eq  output  1  A == B
- lt  output  1  A < B
- bits_checked  output  CW  bits examined by the last comparison, 1..WIDTH

## Operation
- Reset: state IDLE; busy, done, gt, eq, lt = 0; bits_checked = 0; shift registers = 0. Reset overrides every other input.
- States are IDLE, SCAN and DONE.
- IDLE:
  - start=1 loads a and b into shift registers sa and sb.
  - Clears gt, eq, lt and bits_checked to 0, then moves to SCAN.
  - start=0 keeps the block in IDLE.
- SCAN (one bit per cycle, on sa[WIDTH-1] and sb[WIDTH-1]):
  - bits_checked increments by 1 every SCAN cycle.
  - If the MSBs differ, gt or lt is set from the bit cell and the state moves to DONE.
  - If the MSBs are equal and this is bit WIDTH, eq=1 and the state moves to DONE.
  - Otherwise sa and sb shift left by 1 and the block stays in SCAN.
- DONE: done=1 for exactly one cycle, then unconditionally back to IDLE. start is ignored in DONE.
- start is ignored in SCAN. Changes on a or b after the accept edge have no effect.
- gt, eq and lt are mutually exclusive. After the first completion exactly one is high.
- gt, eq, lt and bits_checked hold their values until the next accept edge, or until reset.
- Comparison is unsigned.

## Timing
- Accept edge E0: start=1 while in IDLE. busy goes high in the following cycle.
- Bit k (k=1..WIDTH, k=1 is the MSB) is evaluated in the cycle after edge E(k-1). Its result registers at edge Ek.
- For a first mismatch at bit k, or k=WIDTH when the operands are equal:
  - busy is high for k cycles.
  - done is high in the cycle after Ek.
  - The block is back in IDLE after E(k+1).
- Latency from the accept edge to the done pulse is k cycles. Best case is 1 (MSB differs), worst case is WIDTH.
- Back-to-back operations: start held high is accepted again in the first IDLE cycle after DONE. The minimum period is k+2 cycles.
- Reset asserted mid-SCAN or in DONE:
  - All outputs are 0 in the next cycle and the state returns to IDLE.
  - No done pulse is issued for the aborted operation.

## Test plan
- Reset: assert rst for 2 cycles with start=1 -> busy=done=gt=eq=lt=0, bits_checked=0. No operation is accepted while rst is high.
- Equal operands, WIDTH=8, a=0xA5, b=0xA5:
  - done is high 8 cycles after the accept edge.
  - eq=1, gt=lt=0, bits_checked=8.
  - busy is high for exactly 8 cycles.
- Early exit on the MSB, a=0x80, b=0x7F -> done 1 cycle after accept, gt=1, bits_checked=1.
- Late exit on the LSB, a=0x12, b=0x13 -> done 8 cycles after accept, lt=1, bits_checked=8.
- Input stability: accept a=0x40, b=0x30 (gt expected at bit 2).
  - Then hold start=1 and change a=0x00, b=0xFF during SCAN.
  - Expect gt=1, bits_checked=2. start is ignored until IDLE.
  - The second operation (0x00 vs 0xFF) is accepted in the cycle after DONE and gives lt=1, bits_checked=1.
- Reset mid-operation: accept a=b=0x55 and assert rst at the third SCAN cycle.
  - All outputs are 0 in the next cycle and no done pulse occurs.
  - A new start after rst is deasserted completes normally.

Source files
------------

// File: rtl/serial_mag_cmp_ctrl.sv
// serial_mag_cmp_ctrl: MSB-first bit-serial unsigned magnitude compare with early exit on first mismatch.
module serial_mag_cmp_ctrl #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [CW-1:0]    bits_checked
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] sa, sb;
    logic ma, mb;
    assign ma = sa[WIDTH-1];
    assign mb = sb[WIDTH-1];
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa <= '0;
            sb <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            gt <= 1'b0;
            eq <= 1'b0;
            lt <= 1'b0;
            bits_checked <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= SCAN;
                    sa <= a;
                    sb <= b;
                    busy <= 1'b1;
                    gt <= 1'b0;
                    eq <= 1'b0;
                    lt <= 1'b0;
                    bits_checked <= '0;
                end
                SCAN: begin
                    bits_checked <= bits_checked + CW'(1);
                    // finish on the first differing bit, or on the LSB when all bits matched
                    if (ma != mb || bits_checked == CW'(WIDTH - 1)) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        gt <= ma & ~mb;
                        eq <= ~(ma ^ mb);
                        lt <= ~ma & mb;
                    end else begin
                        sa <= sa << 1;
                        sb <= sb << 1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_mag_cmp_ctrl.sv
// tb_serial_mag_cmp_ctrl: randomized and directed checks against a first-mismatch reference model.
module tb_serial_mag_cmp_ctrl;
    localparam int WIDTH = 8;
    localparam int CW = $clog2(WIDTH) + 1;

    logic clk = 0, rst = 0, start = 0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic busy, done, gt, eq, lt;
    logic [CW-1:0] bits_checked;
    int checks = 0, errors = 0;

    serial_mag_cmp_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .gt(gt), .eq(eq), .lt(lt),
        .bits_checked(bits_checked)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: k is the 1-based position (from MSB) of the first differing bit, WIDTH if equal.
    task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output int k, output logic [2:0] res);
        k = WIDTH;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (x[i] != y[i]) begin
                k = WIDTH - i;
                break;
            end
        res = {x > y, x == y, x < y};
    endtask

    // Launch one op from IDLE; returns cycles until done, busy-cycle count and captured result.
    task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         output int lat, output int bcnt, output logic [2:0] res,
                         output logic [CW-1:0] bc);
        int n;
        start = 1; a = x; b = y;
        tick();
        start = 0;
        bcnt = busy ? 1 : 0;
        lat = -1;
        n = 0;
        while (n < 3 * WIDTH) begin
            tick();
            n++;
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
        res = {gt, eq, lt};
        bc = bits_checked;
    endtask

    task automatic test_reset();
        rst = 1; start = 1; a = 8'hA5; b = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({busy, done, gt, eq, lt, bits_checked} !== '0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: got busy=%b done=%b gt=%b eq=%b lt=%b bc=%0d, want all 0",
                         i, busy, done, gt, eq, lt, bits_checked);
            end
        end
        rst = 0; start = 0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: got busy=%b, want 0", busy);
        end
    endtask

    task automatic directed(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int lat, bcnt, k;
        logic [2:0] res, eres;
        logic [CW-1:0] bc;
        model(x, y, k, eres);
        do_op(x, y, lat, bcnt, res, bc);
        checks++;
        if (lat !== k || bcnt !== k) begin
            errors++;
            $display("FAIL %s_timing: got latency=%0d busy_cycles=%0d, want %0d/%0d", name, lat, bcnt, k, k);
        end
        checks++;
        if (res !== eres || bc !== CW'(k)) begin
            errors++;
            $display("FAIL %s_result: got gt/eq/lt=%b bc=%0d, want %b bc=%0d", name, res, bc, eres, k);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {gt, eq, lt} !== eres) begin
            errors++;
            $display("FAIL %s_hold: got done=%b busy=%b gt/eq/lt=%b, want 0 0 %b", name, done, busy, {gt, eq, lt}, eres);
        end
    endtask

    task automatic test_directed();
        directed("equal", 8'hA5, 8'hA5);
        directed("msb_exit", 8'h80, 8'h7F);
        directed("lsb_exit", 8'h12, 8'h13);
    endtask

    task automatic test_input_stability();
        start = 1; a = 8'h40; b = 8'h30;
        tick();
        a = 8'h00; b = 8'hFF;
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || {gt, eq, lt} !== 3'b100 || bits_checked !== CW'(2)) begin
            errors++;
            $display("FAIL stab_first: got done=%b gt/eq/lt=%b bc=%0d, want 1 100 2", done, {gt, eq, lt}, bits_checked);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || gt !== 1'b1) begin
            errors++;
            $display("FAIL stab_idle: got busy=%b done=%b gt=%b, want 0 0 1", busy, done, gt);
        end
        tick();
        start = 0;
        checks++;
        if (busy !== 1'b1 || {gt, eq, lt} !== 3'b000 || bits_checked !== '0) begin
            errors++;
            $display("FAIL stab_accept2: got busy=%b gt/eq/lt=%b bc=%0d, want 1 000 0", busy, {gt, eq, lt}, bits_checked);
        end
        tick();
        checks++;
        if (done !== 1'b1 || {gt, eq, lt} !== 3'b001 || bits_checked !== CW'(1)) begin
            errors++;
            $display("FAIL stab_second: got done=%b gt/eq/lt=%b bc=%0d, want 1 001 1", done, {gt, eq, lt}, bits_checked);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        logic [2:0] res;
        logic [CW-1:0] bc;
        logic seen;
        start = 1; a = 8'h55; b = 8'h55;
        tick();
        start = 0;
        tick();
        tick();
        rst = 1;
        tick();
        checks++;
        if ({busy, done, gt, eq, lt, bits_checked} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy=%b done=%b gt/eq/lt=%b bc=%0d, want all 0",
                     busy, done, {gt, eq, lt}, bits_checked);
        end
        rst = 0;
        seen = 0;
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            if (done || busy) seen = 1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_done: got activity=%b, want 0", seen);
        end
        do_op(8'h55, 8'h54, lat, bcnt, res, bc);
        checks++;
        if (lat !== 8 || res !== 3'b100 || bc !== CW'(8)) begin
            errors++;
            $display("FAIL rstmid_after: got lat=%0d gt/eq/lt=%b bc=%0d, want 8 100 8", lat, res, bc);
        end
        tick();
    endtask

    task automatic test_random();
        int lat, bcnt, k;
        logic [2:0] res, eres;
        logic [CW-1:0] bc;
        logic [WIDTH-1:0] x, y;
        for (int i = 0; i < 40; i++) begin
            x = WIDTH'($urandom);
            y = (i % 4 == 0) ? x : ((i % 4 == 1) ? x ^ WIDTH'(1 << $urandom_range(WIDTH - 1)) : WIDTH'($urandom));
            model(x, y, k, eres);
            do_op(x, y, lat, bcnt, res, bc);
            checks++;
            if (lat !== k || bcnt !== k || res !== eres || bc !== CW'(k)) begin
                errors++;
                $display("FAIL random a=%h b=%h: got lat=%0d busy=%0d gt/eq/lt=%b bc=%0d, want lat=%0d busy=%0d %b bc=%0d",
                         x, y, lat, bcnt, res, bc, k, k, eres, k);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int k, c, expc;
        logic [2:0] eres;
        logic [WIDTH-1:0] x, y;
        start = 1;
        for (int i = 0; i < 12; i++) begin
            x = WIDTH'($urandom);
            y = (i % 3 == 0) ? x : WIDTH'($urandom);
            a = x; b = y;
            model(x, y, k, eres);
            expc = (i == 0) ? k + 1 : k + 2;
            c = 0;
            while (c < 4 * WIDTH) begin
                tick();
                c++;
                if (done) break;
            end
            checks++;
            if (c !== expc || {gt, eq, lt} !== eres || bits_checked !== CW'(k)) begin
                errors++;
                $display("FAIL b2b op%0d a=%h b=%h: got period=%0d gt/eq/lt=%b bc=%0d, want %0d %b %0d",
                         i, x, y, c, {gt, eq, lt}, bits_checked, expc, eres, k);
            end
        end
        start = 0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_input_stability();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
